// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver: converts a 13-bit binary value to BCD
// with a double-dabble FSM and scans the digits with optional leading-zero blanking.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        busy
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      r_state;
  logic [28:0] r_sh;
  logic [3:0]  r_shCnt;
  logic [12:0] r_lastVal;
  logic        r_first;
  logic [15:0] r_disp;

  state_t      w_stateNext;
  logic [28:0] w_shNext;
  logic [28:0] w_adj;
  logic [3:0]  w_shCntNext;
  logic [12:0] w_lastValNext;
  logic        w_firstNext;
  logic [15:0] w_dispNext;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_anode;
  logic [6:0]       r_seg;

  logic [3:0]  w_anode;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [6:0]  w_seg;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    w_adj = r_sh;
    for (int i = 0; i < 4; i++) begin
      if (r_sh[13 + 4*i +: 4] >= 4'd5)
        w_adj[13 + 4*i +: 4] = r_sh[13 + 4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_shNext      = r_sh;
    w_shCntNext   = r_shCnt;
    w_lastValNext = r_lastVal;
    w_firstNext   = r_first;
    w_dispNext    = r_disp;
    case (r_state)
      IDLE: begin
        if ((value != r_lastVal) || r_first) begin
          w_shNext      = {16'b0, value};
          w_shCntNext   = 4'd0;
          w_lastValNext = value;
          w_firstNext   = 1'b0;
          w_stateNext   = SHIFT;
        end
      end
      SHIFT: begin
        w_shNext    = w_adj << 1;
        w_shCntNext = r_shCnt + 4'd1;
        if (r_shCnt == 4'd12) w_stateNext = DONE;
      end
      DONE: begin
        w_dispNext  = r_sh[28:13];
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sh      <= '0;
      r_shCnt   <= '0;
      r_lastVal <= '0;
      r_first   <= 1'b1;
      r_disp    <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_sh      <= w_shNext;
      r_shCnt   <= w_shCntNext;
      r_lastVal <= w_lastValNext;
      r_first   <= w_firstNext;
      r_disp    <= w_dispNext;
    end
  end

  // A digit above the ones place is blank when it and every higher digit are zero.
  always_comb begin
    w_anode = ~(4'b0001 << r_idx);
    w_nib   = r_disp[{r_idx, 2'b00} +: 4];
    w_blank = BLANK_LZ && (r_idx != 2'd0) && ((r_disp >> {r_idx, 2'b00}) == 16'd0);
    case (w_nib)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      default: w_seg = 7'b1111111;
    endcase
    if (w_blank) w_seg = 7'b1111111;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_anode <= 4'b1111;
      r_seg   <= 7'b1111111;
    end else begin
      if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_anode <= w_anode;
      r_seg   <= w_seg;
    end
  end

  assign anode = r_anode;
  assign seg   = r_seg;
  assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expected BCD results are queued when a value is
// driven and checked when busy falls; the scan is checked on two instances (blanking on/off).
module tb_seg7_scan_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] value;
  logic [3:0]  anode, anodeNb;
  logic [6:0]  seg, segNb;
  logic        busy, busyNb;

  int passCnt = 0;
  int totalCnt = 0;
  logic [15:0] expQ[$];
  logic [15:0] curDisp = 16'h0000;

  seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .anode(anode), .seg(seg), .busy(busy)
  );

  seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .value(value), .anode(anodeNb), .seg(segNb), .busy(busyNb)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] toBcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] expSeg(logic [15:0] d, int k, bit blank);
    logic [15:0] hi;
    logic [3:0]  n;
    hi = d >> (4 * k);
    n  = hi[3:0];
    if (blank && k > 0 && hi == 16'd0) return 7'b1111111;
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for busy to fall; reports cycles taken and disp just before the fall.
  task automatic waitBusyFall(output int cyc, output bit ok, output logic [15:0] prevDisp);
    cyc = 0;
    ok = 1'b0;
    prevDisp = dut.r_disp;
    for (int i = 0; i < 40; i++) begin
      prevDisp = dut.r_disp;
      tick();
      cyc++;
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    bit ok;
    logic [15:0] pd, exp;
    rst = 1'b1;
    value = 13'd0;
    repeat (3) tick();
    totalCnt++; if (anode !== 4'b1111) $display("[TB] FAIL reset_anode: got %b want 1111", anode); else passCnt++;
    totalCnt++; if (seg !== 7'b1111111) $display("[TB] FAIL reset_seg: got %b want 1111111", seg); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passCnt++;
    totalCnt++; if (dut.r_disp !== 16'h0000) $display("[TB] FAIL reset_disp: got %h want 0000", dut.r_disp); else passCnt++;
    rst = 1'b0;
    expQ.push_back(toBcd(0));
    tick();
    totalCnt++; if (anode !== 4'b1110) $display("[TB] FAIL release_anode: got %b want 1110", anode); else passCnt++;
    totalCnt++; if (seg !== 7'b1000000) $display("[TB] FAIL release_seg: got %b want 1000000", seg); else passCnt++;
    totalCnt++; if (busy !== 1'b1) $display("[TB] FAIL release_busy: got %b want 1", busy); else passCnt++;
    waitBusyFall(cyc, ok, pd);
    totalCnt++; if (!ok || cyc != 14) $display("[TB] FAIL reset_conv_len: got %0d ok=%0d want 14", cyc, ok); else passCnt++;
    if (expQ.size() > 0) exp = expQ.pop_front(); else exp = 'x;
    totalCnt++; if (dut.r_disp !== exp) $display("[TB] FAIL reset_conv_disp: got %h want %h", dut.r_disp, exp); else passCnt++;
    curDisp = exp;
  endtask

  task automatic test_conversion(string name, int v);
    int cyc;
    bit ok;
    logic [15:0] pd, exp;
    value = 13'(v);
    expQ.push_back(toBcd(v));
    tick();
    totalCnt++; if (busy !== 1'b1) $display("[TB] FAIL %s_start: busy got %b want 1", name, busy); else passCnt++;
    waitBusyFall(cyc, ok, pd);
    totalCnt++; if (!ok || cyc != 14) $display("[TB] FAIL %s_len: got %0d ok=%0d want 14", name, cyc, ok); else passCnt++;
    totalCnt++; if (pd !== curDisp) $display("[TB] FAIL %s_early: disp got %h want %h", name, pd, curDisp); else passCnt++;
    if (expQ.size() > 0) exp = expQ.pop_front(); else exp = 'x;
    totalCnt++; if (dut.r_disp !== exp) $display("[TB] FAIL %s_disp: got %h want %h", name, dut.r_disp, exp); else passCnt++;
    curDisp = exp;
  endtask

  task automatic test_scan_pattern(string name, logic [15:0] d);
    logic [3:0] prevA, ea;
    bit found;
    found = 1'b0;
    prevA = anode;
    for (int i = 0; i < 8 * DIV; i++) begin
      tick();
      if (anode === 4'b1110 && prevA !== 4'b1110) begin
        found = 1'b1;
        break;
      end
      prevA = anode;
    end
    totalCnt++; if (!found) $display("[TB] FAIL %s_scan_start: anode got %b want 1110", name, anode); else passCnt++;
    if (found) begin
      for (int k = 0; k < 4; k++) begin
        ea = 4'b1111;
        ea[k] = 1'b0;
        for (int c = 0; c < DIV; c++) begin
          if (k != 0 || c != 0) tick();
          totalCnt++; if (anode !== ea) $display("[TB] FAIL %s_anode d%0d c%0d: got %b want %b", name, k, c, anode, ea); else passCnt++;
          totalCnt++; if (anodeNb !== ea) $display("[TB] FAIL %s_anode_nb d%0d c%0d: got %b want %b", name, k, c, anodeNb, ea); else passCnt++;
          totalCnt++; if (seg !== expSeg(d, k, 1'b1)) $display("[TB] FAIL %s_seg d%0d c%0d: got %b want %b", name, k, c, seg, expSeg(d, k, 1'b1)); else passCnt++;
          totalCnt++; if (segNb !== expSeg(d, k, 1'b0)) $display("[TB] FAIL %s_seg_nb d%0d c%0d: got %b want %b", name, k, c, segNb, expSeg(d, k, 1'b0)); else passCnt++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    logic [15:0] pd, exp;
    value = 13'd100;
    expQ.push_back(toBcd(100));
    tick();
    totalCnt++; if (busy !== 1'b1) $display("[TB] FAIL b2b_start: busy got %b want 1", busy); else passCnt++;
    repeat (5) tick();
    value = 13'd7;
    expQ.push_back(toBcd(7));
    waitBusyFall(cyc, ok, pd);
    totalCnt++; if (!ok || cyc != 9) $display("[TB] FAIL b2b_first_len: got %0d ok=%0d want 9", cyc, ok); else passCnt++;
    totalCnt++; if (pd !== curDisp) $display("[TB] FAIL b2b_first_early: disp got %h want %h", pd, curDisp); else passCnt++;
    if (expQ.size() > 0) exp = expQ.pop_front(); else exp = 'x;
    totalCnt++; if (dut.r_disp !== exp) $display("[TB] FAIL b2b_first_disp: got %h want %h", dut.r_disp, exp); else passCnt++;
    curDisp = exp;
    tick();
    totalCnt++; if (busy !== 1'b1) $display("[TB] FAIL b2b_restart: busy got %b want 1", busy); else passCnt++;
    waitBusyFall(cyc, ok, pd);
    totalCnt++; if (!ok || cyc != 14) $display("[TB] FAIL b2b_second_len: got %0d ok=%0d want 14", cyc, ok); else passCnt++;
    totalCnt++; if (pd !== curDisp) $display("[TB] FAIL b2b_second_early: disp got %h want %h", pd, curDisp); else passCnt++;
    if (expQ.size() > 0) exp = expQ.pop_front(); else exp = 'x;
    totalCnt++; if (dut.r_disp !== exp) $display("[TB] FAIL b2b_second_disp: got %h want %h", dut.r_disp, exp); else passCnt++;
    curDisp = exp;
  endtask

  task automatic test_reset_abort();
    int cyc;
    bit ok;
    logic [15:0] pd, exp;
    value = 13'd1234;
    tick();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    totalCnt++; if (anode !== 4'b1111) $display("[TB] FAIL abort_anode: got %b want 1111", anode); else passCnt++;
    totalCnt++; if (seg !== 7'b1111111) $display("[TB] FAIL abort_seg: got %b want 1111111", seg); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b want 0", busy); else passCnt++;
    totalCnt++; if (dut.r_disp !== 16'h0000) $display("[TB] FAIL abort_disp: got %h want 0000", dut.r_disp); else passCnt++;
    rst = 1'b0;
    curDisp = 16'h0000;
    expQ.push_back(toBcd(1234));
    tick();
    totalCnt++; if (busy !== 1'b1 || anode !== 4'b1110) $display("[TB] FAIL abort_restart: busy=%b anode=%b want 1/1110", busy, anode); else passCnt++;
    waitBusyFall(cyc, ok, pd);
    totalCnt++; if (!ok || cyc != 14) $display("[TB] FAIL abort_len: got %0d ok=%0d want 14", cyc, ok); else passCnt++;
    totalCnt++; if (pd !== 16'h0000) $display("[TB] FAIL abort_partial: disp got %h want 0000", pd); else passCnt++;
    if (expQ.size() > 0) exp = expQ.pop_front(); else exp = 'x;
    totalCnt++; if (dut.r_disp !== exp) $display("[TB] FAIL abort_disp_final: got %h want %h", dut.r_disp, exp); else passCnt++;
    curDisp = exp;
  endtask

  task automatic test_steady();
    int busyHigh, starts, badGap, lastStart;
    logic [3:0] prevA;
    busyHigh = 0;
    starts = 0;
    badGap = 0;
    lastStart = -1;
    prevA = anode;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (busy !== 1'b0) busyHigh++;
      if (anode === 4'b1110 && prevA !== 4'b1110) begin
        if (lastStart >= 0 && (i - lastStart) != 4 * DIV) badGap++;
        lastStart = i;
        starts++;
      end
      prevA = anode;
    end
    totalCnt++; if (busyHigh != 0) $display("[TB] FAIL steady_busy: high for %0d cycles want 0", busyHigh); else passCnt++;
    totalCnt++; if (badGap != 0) $display("[TB] FAIL steady_period: %0d bad periods want 0", badGap); else passCnt++;
    totalCnt++; if (starts < 60) $display("[TB] FAIL steady_scans: got %0d scan starts want >= 60", starts); else passCnt++;
    totalCnt++; if (dut.r_disp !== curDisp) $display("[TB] FAIL steady_disp: got %h want %h", dut.r_disp, curDisp); else passCnt++;
  endtask

  initial begin
    rst = 1'b1;
    value = 13'd0;
    test_reset();
    test_scan_pattern("zero", curDisp);
    test_conversion("max", 8191);
    test_scan_pattern("max", 16'h8191);
    test_conversion("v42", 42);
    test_scan_pattern("v42", 16'h0042);
    test_back_to_back();
    test_scan_pattern("v7", 16'h0007);
    test_reset_abort();
    test_scan_pattern("v1234", 16'h1234);
    test_steady();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
